// File: rtl/bit_serial_adder.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first,
// carries its cout between bits and assembles the WIDTH-bit sum plus carry-out.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Widening by one bit keeps the shift-in legal when WIDTH is 1.
    logic [WIDTH:0]   accExt;
    logic [WIDTH-1:0] accShifted;

    assign accExt     = {fa_sum, acc_q};
    assign accShifted = accExt[WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = accShifted;
                carry_d = fa_cout;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = accShifted;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The full adder only sees live operands while RUN; otherwise it is held at zero.
    always_comb begin
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state_q == RUN) begin
            fa_a   = a_sh_q[0];
            fa_b   = b_sh_q[0];
            fa_cin = carry_q;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder with a behavioural 1-bit full adder
// closing the loop on the fa_* ports.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int testsRun;
    int testsFailed;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_cin (fa_cin),
        .fa_sum (fa_sum),
        .fa_cout(fa_cout),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    // External full adder the sequencer drives.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] opA;
        logic [W-1:0] opB;
        logic         opCin;
        logic [W-1:0] expSum;
        logic         expCout;
        string        name;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One complete operation: start pulse, bounded wait for done, result and timing checks.
    task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                 input logic opCin, input logic [W-1:0] expSum,
                                 input logic expCout, input string name);
        int  cycles;
        int  busyCnt;
        bit  seen;
        @(negedge clk);
        a     = opA;
        b     = opB;
        cin   = opCin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles  = 0;
        busyCnt = 0;
        seen    = 1'b0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (busy) busyCnt++;
            if (done) seen = 1'b1;
        end
        checkOutput({name, " latency"}, 32'(cycles), 32'(W + 1));
        checkOutput({name, " busy cycles"}, 32'(busyCnt), 32'(W + 1));
        checkOutput({name, " sum"}, 32'(sum), 32'(expSum));
        checkOutput({name, " cout"}, 32'(cout), 32'(expCout));
    endtask

    initial begin
        int           cycles;
        int           doneCount;
        logic [W-1:0] faBits;
        logic         prevCout;
        logic [W:0]   expTotal;
        logic [W-1:0] rA;
        logic [W-1:0] rB;
        logic         rC;

        testsRun    = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01"};
        vecs[1] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "3c+0f"};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5+5a+1"};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "10+20"};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00+00"};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff+ff+1"};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80+80"};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, "55+aa"};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        checkOutput("reset fa bits", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].opCin,
                          vecs[i].expSum, vecs[i].expCout, vecs[i].name);
        end

        // Bit-level view of 0x3C + 0x0F: fa_a order and carry chaining
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        prevCout = 1'b0;
        faBits   = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            faBits[i] = fa_a;
            checkOutput($sformatf("fa_cin bit %0d", i), 32'(fa_cin), 32'(prevCout));
            prevCout = fa_cout;
        end
        checkOutput("fa_a sequence", 32'(faBits), 32'h3C);
        @(negedge clk);
        checkOutput("seq done", 32'(done), 32'd1);
        checkOutput("seq sum", 32'(sum), 32'h4B);

        // start held high: second add accepted right after DONE returns to IDLE
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("hold first latency", 32'(cycles), 32'(W + 1));
        checkOutput("hold first sum", 32'({cout, sum}), 32'h100);
        a = 8'h01; b = 8'h02; cin = 1'b0;
        @(negedge clk);
        checkOutput("hold idle gap busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("hold second accepted", 32'(busy), 32'd1);
        start = 1'b0;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("hold second latency", 32'(cycles), 32'(W));
        checkOutput("hold second sum", 32'({cout, sum}), 32'h003);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        doneCount = 0;
        for (int i = 1; i <= 2 * W + 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a = 8'h01; b = 8'h01; start = 1'b1;
            end else if (i == 4) begin
                start = 1'b0;
            end
            if (done) doneCount++;
        end
        checkOutput("mid-run start done count", 32'(doneCount), 32'd1);
        checkOutput("mid-run start result", 32'({cout, sum}), 32'h030);
        checkOutput("mid-run start idle after", 32'(busy), 32'd0);

        // Asynchronous reset during RUN
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset sum", 32'(sum), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) doneCount++;
        end
        checkOutput("no activity after reset", 32'(doneCount), 32'd0);
        applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "post-reset 12+34+1");

        // Back-to-back random operations
        for (int i = 0; i < 1000; i++) begin
            rA = W'($urandom);
            rB = W'($urandom);
            rC = 1'($urandom_range(0, 1));
            expTotal = (W + 1)'(rA) + (W + 1)'(rB) + (W + 1)'(rC);
            applyStimulus(rA, rB, rC, expTotal[W-1:0], expTotal[W],
                          $sformatf("rand %0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
